// File: rtl/fdiv_seq_if.sv
// Operand/result bus of the sequential single-precision divider fdiv_seq.
// Both sides are valid/ready. A transfer happens on a rising edge where valid and ready are both high. The sender holds its payload stable while valid=1 and ready=0.
interface fdiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_num;
  logic        flag_invalid;
  logic        flag_dz;
  logic        flag_of;
  logic        flag_uf;
  logic        flag_nx;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, out_num,
    input  flag_invalid, flag_dz, flag_of, flag_uf, flag_nx
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, out_num,
    output flag_invalid, flag_dz, flag_of, flag_uf, flag_nx
  );
endinterface

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider (num1/num2) built on a radix-2 restoring mantissa divider.
// Optional macro FDIV_ROUND_NEAREST_EN selects round-to-nearest-even. Without it the result is truncated toward zero.
module fdiv_seq #(
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  fdiv_seq_if.slave  bus,
  output logic [2:0] state_o
);

  localparam logic [2:0]  S_IDLE    = 3'd0;
  localparam logic [2:0]  S_PREP    = 3'd1;
  localparam logic [2:0]  S_DIV     = 3'd2;
  localparam logic [2:0]  S_NORM    = 3'd3;
  localparam logic [2:0]  S_DONE    = 3'd4;
  localparam logic [4:0]  LAST_ITER = 5'd25;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  logic [2:0]        state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [24:0]       r_q, r_d;
  logic [23:0]       mb_q, mb_d;
  logic [25:0]       q_q, q_d;
  logic signed [9:0] e_q, e_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              special_q, special_d;
  logic [31:0]       res_q, res_d;
  // flags packed as {invalid, dz, of, uf, nx}
  logic [4:0]        flags_q, flags_d;

  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic       sign_r;

  assign a_exp  = a_q[30:23];
  assign b_exp  = b_q[30:23];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
  assign sign_r = a_q[31] ^ b_q[31];

  // Special-case decode. Exponent 0 counts as zero, so denormal operands are flushed.
  logic        sp_hit;
  logic [31:0] sp_res;
  logic [4:0]  sp_flags;

  always_comb begin
    sp_hit   = 1'b1;
    sp_res   = QNAN;
    sp_flags = 5'b00000;
    if (a_nan || b_nan) begin
      sp_res = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res   = QNAN;
      sp_flags = 5'b10000;
    end else if (a_inf) begin
      sp_res = {sign_r, 8'hFF, 23'd0};
    end else if (b_zero) begin
      sp_res   = {sign_r, 8'hFF, 23'd0};
      sp_flags = 5'b01000;
    end else if (b_inf || a_zero) begin
      sp_res = {sign_r, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring step. The partial remainder always stays below 2*mb, so 25 bits hold it.
  logic        step_ge;
  logic [24:0] step_rem;

  assign step_ge  = (r_q >= {1'b0, mb_q});
  assign step_rem = step_ge ? (r_q - {1'b0, mb_q}) : r_q;

  // Normalise, round and pack.
  logic [23:0]       n_mant;
  logic              n_guard, n_sticky;
  logic signed [9:0] n_exp;
  logic              round_up;
  logic [24:0]       n_sum;
  logic [22:0]       r_frac;
  logic signed [9:0] r_exp;
  logic [31:0]       norm_res;
  logic [4:0]        norm_flags;

  always_comb begin
    if (q_q[25]) begin
      n_mant   = q_q[25:2];
      n_guard  = q_q[1];
      n_sticky = q_q[0] | (r_q != 25'd0);
      n_exp    = e_q;
    end else begin
      n_mant   = q_q[24:1];
      n_guard  = q_q[0];
      n_sticky = (r_q != 25'd0);
      n_exp    = e_q - 10'sd1;
    end
  end

`ifdef FDIV_ROUND_NEAREST_EN
  assign round_up = n_guard & (n_sticky | n_mant[0]);
`else
  assign round_up = 1'b0;
`endif

  assign n_sum = {1'b0, n_mant} + {24'd0, round_up};

  always_comb begin
    if (n_sum[24]) begin
      r_frac = n_sum[23:1];
      r_exp  = n_exp + 10'sd1;
    end else begin
      r_frac = n_sum[22:0];
      r_exp  = n_exp;
    end
  end

  always_comb begin
    if (r_exp >= 10'sd255) begin
      norm_res   = {sign_r, 8'hFF, 23'd0};
      norm_flags = 5'b00101;
    end else if (r_exp <= 10'sd0) begin
      norm_res   = {sign_r, 31'd0};
      norm_flags = 5'b00011;
    end else begin
      norm_res   = {sign_r, r_exp[7:0], r_frac};
      norm_flags = {4'b0000, n_guard | n_sticky};
    end
  end

  // Control. A special result rides through DIV/NORM untouched when SPECIAL_FAST=0.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    mb_d      = mb_q;
    q_d       = q_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    special_d = special_q;
    res_d     = res_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.num1;
          b_d     = bus.num2;
          res_d   = 32'd0;
          flags_d = 5'b00000;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        cnt_d     = 5'd0;
        special_d = sp_hit;
        if (sp_hit) begin
          res_d   = sp_res;
          flags_d = sp_flags;
          state_d = SPECIAL_FAST ? S_DONE : S_DIV;
        end else begin
          r_d     = {2'b01, a_q[22:0]};
          mb_d    = {1'b1, b_q[22:0]};
          q_d     = 26'd0;
          e_d     = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (!special_q) begin
          q_d = {q_q[24:0], step_ge};
          r_d = step_rem << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (!special_q) begin
          res_d   = norm_res;
          flags_d = norm_flags;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      r_q       <= 25'd0;
      mb_q      <= 24'd0;
      q_q       <= 26'd0;
      e_q       <= 10'sd0;
      cnt_q     <= 5'd0;
      special_q <= 1'b0;
      res_q     <= 32'd0;
      flags_q   <= 5'b00000;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      mb_q      <= mb_d;
      q_q       <= q_d;
      e_q       <= e_d;
      cnt_q     <= cnt_d;
      special_q <= special_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.out_valid    = (state_q == S_DONE);
  assign bus.out_num      = res_q;
  assign bus.flag_invalid = flags_q[4];
  assign bus.flag_dz      = flags_q[3];
  assign bus.flag_of      = flags_q[2];
  assign bus.flag_uf      = flags_q[1];
  assign bus.flag_nx      = flags_q[0];
  assign state_o          = state_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: directed vector table, stall/reset sequences and random operands checked against an integer-division model.
module tb_fdiv_seq;

  localparam bit SF = 1'b1;
  localparam int SP_LAT = SF ? 1 : 28;
`ifdef FDIV_ROUND_NEAREST_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAA_AAAA;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  fdiv_seq_if bus();

  fdiv_seq #(.SPECIAL_FAST(SF)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [4:0] cur_flags();
    return {bus.flag_invalid, bus.flag_dz, bus.flag_of, bus.flag_uf, bus.flag_nx};
  endfunction

  // Reference: the quotient comes from one exact integer division, then normalise/round from the rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [4:0] fl,
                                  output bit special);
    logic s;
    int ea, eb, e;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    bit g, st;
    longint unsigned num, den, qt, rm, mant;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    fl = 5'b00000;
    special = 1'b1;
    res = 32'h7FC0_0000;
    if (a_nan || b_nan) res = 32'h7FC0_0000;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) fl = 5'b10000;
    else if (a_inf) res = {s, 8'hFF, 23'd0};
    else if (b_zero) begin res = {s, 8'hFF, 23'd0}; fl = 5'b01000; end
    else if (b_inf || a_zero) res = {s, 31'd0};
    else begin
      special = 1'b0;
      num = longint'({1'b1, a[22:0]}) << 25;
      den = longint'({1'b1, b[22:0]});
      qt  = num / den;
      rm  = num % den;
      e   = ea - eb + 127;
      if (qt >= (64'd1 << 25)) begin
        mant = qt >> 2; g = qt[1]; st = qt[0] || (rm != 0);
      end else begin
        mant = qt >> 1; g = qt[0]; st = (rm != 0); e = e - 1;
      end
`ifdef FDIV_ROUND_NEAREST_EN
      if (g && (st || mant[0])) mant = mant + 1;
`endif
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) begin res = {s, 8'hFF, 23'd0}; fl = 5'b00101; end
      else if (e <= 0) begin res = {s, 31'd0}; fl = 5'b00011; end
      else begin res = {s, 8'(e), mant[22:0]}; fl = {4'b0000, g | st}; end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    bus.num1 = a;
    bus.num2 = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] res, output logic [4:0] fl, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
    res = bus.out_num;
    fl  = cur_flags();
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    start_op(a, b);
    wait_result(res, fl, lat);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp_list[7];
    int mode;
    sp_list[0] = 32'h0000_0000; sp_list[1] = 32'h8000_0000; sp_list[2] = 32'h7F80_0000;
    sp_list[3] = 32'hFF80_0000; sp_list[4] = 32'h7FC0_0000; sp_list[5] = 32'h0000_0001;
    sp_list[6] = 32'h7F80_0001;
    mode = $urandom_range(0, 9);
    if (mode == 0) return sp_list[$urandom_range(0, 6)];
    if (mode <= 3) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] res, hold_res, exp_res, a, b;
    logic [4:0]  fl, hold_fl, exp_fl;
    bit          sp;
    int          lat, seen;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 28};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, ONE_THIRD,     5'b00001, 28};
    vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000, SP_LAT};
    vecs[3]  = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 5'b10000, SP_LAT};
    vecs[4]  = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 5'b00101, 28};
    vecs[5]  = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 5'b00011, 28};
    vecs[6]  = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b00000, SP_LAT};
    vecs[7]  = '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 5'b00000, SP_LAT};
    vecs[8]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 5'b00000, SP_LAT};
    vecs[9]  = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 5'b00000, 28};
    vecs[10] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000, SP_LAT};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.num1 = 32'd0;
    bus.num2 = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_num", bus.out_num, 32'd0);
    check("rst_flags", {27'd0, cur_flags()}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, fl, lat);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_flags", i), {27'd0, fl}, {27'd0, vecs[i].exp_fl});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Held result under backpressure, then back-to-back 1/3.
    bus.out_ready = 1'b0;
    start_op(32'h40C0_0000, 32'h4000_0000);
    wait_result(hold_res, hold_fl, lat);
    check("stall_res", hold_res, 32'h4040_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_num", bus.out_num, 32'h4040_0000);
      check("stall_flags", {27'd0, cur_flags()}, 32'd0);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    do_op(32'h3F80_0000, 32'h4040_0000, res, fl, lat);
    check("b2b_res", res, ONE_THIRD);
    check("b2b_nx", {27'd0, fl}, 32'd1);

    // Reset during the tenth divide iteration.
    start_op(32'h40C0_0000, 32'h4000_0000);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    do_op(32'h40C0_0000, 32'h4000_0000, res, fl, lat);
    check("after_abort_res", res, 32'h4040_0000);
    check("after_abort_lat", 32'(lat), 32'd28);

    for (int i = 0; i < 200; i++) begin
      a = rand_operand();
      b = rand_operand();
      ref_div(a, b, exp_res, exp_fl, sp);
      do_op(a, b, res, fl, lat);
      check($sformatf("rand%0d_res %h/%h", i, a, b), res, exp_res);
      check($sformatf("rand%0d_flags", i), {27'd0, fl}, {27'd0, exp_fl});
      check($sformatf("rand%0d_lat", i), 32'(lat), sp ? 32'(SP_LAT) : 32'd28);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Sequential IEEE-754 single-precision divider, res = num1 / num2, using a radix-2 restoring mantissa divider.
- Complements the combinational fmul/fadd/fmadd datapath; it is the FPU's inverse-of-multiply unit.
- Valid/ready on both sides, one operation in flight.

Parameters:
SPECIAL_FAST, 1, 1: special-case results complete after 1 edge; 0: all operations take the full fixed latency

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands valid
in_ready  out  1  unit idle, can accept
num1  in  32  dividend
num2  in  32  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_num  out  32  quotient
flag_invalid  out  1  invalid operation
flag_dz  out  1  divide by zero
flag_of  out  1  overflow
flag_uf  out  1  underflow
flag_nx  out  1  inexact

Behaviour:
- Clocking/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_num=0, all flags 0.
- Reset mid-operation aborts the operation: next cycle is IDLE, no result is emitted.
- States: IDLE, PREP, DIV, NORM, DONE.
- in_ready = (state==IDLE).
- Accept edge E0 (in_valid & in_ready) captures num1/num2 and moves to PREP.
- PREP (edge E1): classify operands. Exponent 0 means zero; denormals are flushed to zero. If a special case applies, load the result; go to DONE when SPECIAL_FAST=1, otherwise wait in DIV for the remaining count. If not special: ma={1,frac1}, mb={1,frac2}, r=ma, e=ea-eb+127 (signed 10-bit), cnt=0, go to DIV.
- DIV (edges E2..E27, 26 iterations): if r>=mb, q bit=1 and r-=mb, else q bit=0; then r<<=1. Quotient bits fill q[25:0], MSB first.
- NORM (edge E28):
  - If q[25]: mant=q[25:2], guard=q[1], sticky=q[0]|(r!=0).
  - Else: mant=q[24:1], guard=q[0], sticky=(r!=0), and e-=1.
  - Round (see macro). A mantissa carry-out renormalises and does e+=1.
  - e>=255: signed Inf, of=1, nx=1.
  - e<=0: signed zero, uf=1, nx=1.
  - Otherwise pack {s,e[7:0],mant[22:0]}; nx=guard|sticky.
  - Go to DONE.
- Latency: normal ops, out_valid rises after edge E28 (28 edges after accept). Specials rise after E1, or after E28 when SPECIAL_FAST=0.
- Sign = sign1 ^ sign2 for all non-NaN results.
- Special cases:
  - Any NaN input -> 0x7FC00000, invalid=0.
  - 0/0 or Inf/Inf -> 0x7FC00000, invalid=1.
  - finite nonzero/0 -> signed Inf, dz=1.
  - Inf/finite -> signed Inf.
  - finite/Inf or 0/nonzero -> signed zero.
- DONE: out_valid=1. out_num and flags are held stable while out_ready=0. On out_valid & out_ready, go to IDLE (in_ready=1 the next cycle). No overlap between operations.
- Flags are meaningful only while out_valid=1. They are cleared when a new operation is accepted.

Optional Feature:
FDIV_ROUND_NEAREST_EN
- Defined: round-to-nearest-even. Increment mant if guard & (sticky | mant[0]).
- Undefined: truncate (round toward zero), mant unchanged.
- Overflow returns Inf in both modes. nx is computed identically in both modes.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> out_num=0x40400000, flags all 0, out_valid exactly 28 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FDIV_ROUND_NEAREST_EN, 0x3EAAAAAA without; nx=1.
- 0x3F800000 / 0x00000000 -> 0x7F800000, dz=1. 0x00000000 / 0x80000000 -> 0x7FC00000, invalid=1. Both at 1-edge latency with SPECIAL_FAST=1, 28 with SPECIAL_FAST=0.
- 0x7F000000 / 0x00800000 -> 0x7F800000, of=1, nx=1. 0x00800000 / 0x7F000000 -> 0x00000000, uf=1, nx=1.
- 6/2 with out_ready held low 10 cycles -> out_num and flags stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle; a back-to-back 1/3 completes correctly.
- Assert rst during DIV iteration 10 -> next cycle in_ready=1, out_valid=0, no result emitted. A subsequent 6/2 returns 0x40400000.
